// File: rtl/myproject_mul_pipe_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : myproject_mul_pipe_mac                                         |
// | Purpose : Pipelined multiplier with optional packet-delimited, saturating|
// |           multiply-accumulate for the LeNet-5 dense/conv datapaths.      |
// |           Each operand is widened by one MSB (sign or zero) and the pair |
// |           is multiplied as signed, so the din0_WIDTH+din1_WIDTH product  |
// |           is exact for every signedness mix. dout is that product        |
// |           truncated. A sideband (valid/first/last) travels with the      |
// |           product; the accumulator sits one stage after the product.     |
// | Ports   : clk, reset (async, active high), ce (stalls every register)    |
// |           in_valid/in_first/in_last, din0, din1      -> beat inputs      |
// |           out_valid, dout                             -> product output   |
// |           acc_valid, acc_out, acc_ovf                 -> packet result    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module myproject_mul_pipe_mac #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 18,
   parameter int din1_WIDTH  = 17,
   parameter int dout_WIDTH  = 24,
   parameter int DIN0_SIGNED = 1,
   parameter int DIN1_SIGNED = 0,
   parameter int MAC_EN      = 1,
   parameter int ACC_WIDTH   = 40
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic                  in_last,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  acc_valid,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  acc_ovf
);

   localparam int c_PW    = din0_WIDTH + din1_WIDTH;
   localparam int c_NS    = (NUM_STAGE < 1) ? 1 : ((NUM_STAGE > 8) ? 8 : NUM_STAGE);
   // With two or more stages the operands get their own register so the
   // multiplier sees registered inputs; the remaining stages hold the product.
   localparam int c_OPREG = (c_NS >= 2) ? 1 : 0;
   localparam int c_PD    = c_NS - c_OPREG;
   // An out-of-range configuration keeps the valid strobes low so a badly
   // parameterised instance stays inert instead of emitting garbage.
   localparam bit c_CFG_OK = (ID >= 0) && (NUM_STAGE >= 1) && (NUM_STAGE <= 8) &&
                             (dout_WIDTH <= c_PW) && (ACC_WIDTH >= c_PW + 1);

   // ---------------------------------------------------------------- operands
   logic [din0_WIDTH-1:0] op0;
   logic [din1_WIDTH-1:0] op1;
   logic                  op_v;
   logic                  op_f;
   logic                  op_l;

   generate
      if (c_OPREG == 1) begin : g_op_reg
         logic [din0_WIDTH-1:0] op0_q, op0_d;
         logic [din1_WIDTH-1:0] op1_q, op1_d;
         logic                  v_q, v_d, f_q, f_d, l_q, l_d;

         always_comb begin
            op0_d = din0;
            op1_d = din1;
            v_d   = in_valid;
            // first/last are meaningless without valid; drop them here
            f_d   = in_valid & in_first;
            l_d   = in_valid & in_last;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               op0_q <= '0;
               op1_q <= '0;
               v_q   <= 1'b0;
               f_q   <= 1'b0;
               l_q   <= 1'b0;
            end else if (ce) begin
               op0_q <= op0_d;
               op1_q <= op1_d;
               v_q   <= v_d;
               f_q   <= f_d;
               l_q   <= l_d;
            end
         end

         assign op0  = op0_q;
         assign op1  = op1_q;
         assign op_v = v_q;
         assign op_f = f_q;
         assign op_l = l_q;
      end else begin : g_op_direct
         assign op0  = din0;
         assign op1  = din1;
         assign op_v = in_valid;
         assign op_f = in_valid & in_first;
         assign op_l = in_valid & in_last;
      end
   endgenerate

   // ---------------------------------------------------------------- multiply
   // Both operands are extended to c_PW+2 bits so the multiply is a plain
   // same-width signed product; the low c_PW bits are the exact result.
   logic                 sgn0;
   logic                 sgn1;
   logic signed [c_PW+1:0] ext0;
   logic signed [c_PW+1:0] ext1;
   logic signed [c_PW+1:0] prod_wide;
   logic [c_PW-1:0]      prod;

   always_comb begin
      sgn0      = (DIN0_SIGNED != 0) & op0[din0_WIDTH-1];
      sgn1      = (DIN1_SIGNED != 0) & op1[din1_WIDTH-1];
      ext0      = {{(c_PW + 2 - din0_WIDTH){sgn0}}, op0};
      ext1      = {{(c_PW + 2 - din1_WIDTH){sgn1}}, op1};
      prod_wide = ext0 * ext1;
      prod      = prod_wide[c_PW-1:0];
   end

   // ------------------------------------------------------- product pipeline
   logic [c_PD-1:0][c_PW-1:0] prod_q, prod_d;
   logic [c_PD-1:0]           vld_q, vld_d;
   logic [c_PD-1:0]           fst_q, fst_d;
   logic [c_PD-1:0]           lst_q, lst_d;

   always_comb begin
      prod_d[0] = prod;
      vld_d[0]  = op_v;
      fst_d[0]  = op_f;
      lst_d[0]  = op_l;
      for (int i = 1; i < c_PD; i++) begin
         prod_d[i] = prod_q[i-1];
         vld_d[i]  = vld_q[i-1];
         fst_d[i]  = fst_q[i-1];
         lst_d[i]  = lst_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod_q <= '0;
         vld_q  <= '0;
         fst_q  <= '0;
         lst_q  <= '0;
      end else if (ce) begin
         prod_q <= prod_d;
         vld_q  <= vld_d;
         fst_q  <= fst_d;
         lst_q  <= lst_d;
      end
   end

   logic [c_PW-1:0] p_out;
   logic            p_vld;
   logic            p_fst;
   logic            p_lst;

   assign p_out     = prod_q[c_PD-1];
   assign p_vld     = vld_q[c_PD-1];
   assign p_fst     = fst_q[c_PD-1];
   assign p_lst     = lst_q[c_PD-1];
   assign out_valid = c_CFG_OK & p_vld;
   assign dout      = p_out[dout_WIDTH-1:0];

   // ------------------------------------------------------------ accumulator
   generate
      if (MAC_EN != 0) begin : g_mac
         localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
         localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

         logic [ACC_WIDTH-1:0] acc_q, acc_d;
         logic                 ovf_q, ovf_d;
         logic                 accv_q, accv_d;
         logic [ACC_WIDTH-1:0] acco_q, acco_d;
         logic                 accovf_q, accovf_d;
         logic [ACC_WIDTH:0]   p_ext;
         logic [ACC_WIDTH:0]   a_ext;
         logic [ACC_WIDTH:0]   sum;

         always_comb begin
            p_ext    = {{(ACC_WIDTH + 1 - c_PW){p_out[c_PW-1]}}, p_out};
            a_ext    = {acc_q[ACC_WIDTH-1], acc_q};
            // One guard bit: the two top bits disagree exactly on overflow
            sum      = a_ext + p_ext;
            acc_d    = acc_q;
            ovf_d    = ovf_q;
            accv_d   = 1'b0;
            acco_d   = acco_q;
            accovf_d = accovf_q;
            if (p_vld) begin
               if (p_fst) begin
                  acc_d = p_ext[ACC_WIDTH-1:0];
                  ovf_d = 1'b0;
               end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                  acc_d = sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
                  ovf_d = 1'b1;
               end else begin
                  acc_d = sum[ACC_WIDTH-1:0];
               end
               // Result registers only move on a last beat, so acc_out holds
               // the previous packet while the next one is being summed.
               if (p_lst) begin
                  accv_d   = 1'b1;
                  acco_d   = acc_d;
                  accovf_d = ovf_d;
               end
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               acc_q    <= '0;
               ovf_q    <= 1'b0;
               accv_q   <= 1'b0;
               acco_q   <= '0;
               accovf_q <= 1'b0;
            end else if (ce) begin
               acc_q    <= acc_d;
               ovf_q    <= ovf_d;
               accv_q   <= accv_d;
               acco_q   <= acco_d;
               accovf_q <= accovf_d;
            end
         end

         assign acc_valid = c_CFG_OK & accv_q;
         assign acc_out   = acco_q;
         assign acc_ovf   = accovf_q;
      end else begin : g_no_mac
         assign acc_valid = 1'b0;
         assign acc_out   = '0;
         assign acc_ovf   = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_myproject_mul_pipe_mac.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_myproject_mul_pipe_mac                                      |
// | Purpose : Self-checking bench for myproject_mul_pipe_mac. A main DUT     |
// |           (signed x unsigned, MAC on) plus three instances covering the  |
// |           other signedness combinations share the same stimulus.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_myproject_mul_pipe_mac;

   localparam int NS = 3;
   localparam int W0 = 18;
   localparam int W1 = 17;
   localparam int WO = 24;
   localparam int AW = 40;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ce = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_first = 1'b0;
   logic          in_last = 1'b0;
   logic [W0-1:0] din0 = '0;
   logic [W1-1:0] din1 = '0;
   logic          out_valid;
   logic [WO-1:0] dout;
   logic          acc_valid;
   logic [AW-1:0] acc_out;
   logic          acc_ovf;

   logic          all_v [0:3];
   logic [WO-1:0] all_d [0:3];

   int n_cmp = 0;
   int n_err = 0;
   int ce_cnt = 0;

   always #5 clk = ~clk;

   myproject_mul_pipe_mac #(
      .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO),
      .DIN0_SIGNED(1), .DIN1_SIGNED(0), .MAC_EN(1), .ACC_WIDTH(AW)
   ) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout),
      .acc_valid(acc_valid), .acc_out(acc_out), .acc_ovf(acc_ovf)
   );

   assign all_v[0] = out_valid;
   assign all_d[0] = dout;

   // g=1: unsigned x unsigned, g=2: unsigned x signed, g=3: signed x signed
   generate
      for (genvar g = 1; g < 4; g++) begin : g_sweep_dut
         logic          x_acc_valid;
         logic [AW-1:0] x_acc_out;
         logic          x_acc_ovf;
         myproject_mul_pipe_mac #(
            .ID(g + 1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO),
            .DIN0_SIGNED((g == 3) ? 1 : 0), .DIN1_SIGNED((g >= 2) ? 1 : 0),
            .MAC_EN(1), .ACC_WIDTH(AW)
         ) u_x (
            .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
            .in_last(in_last), .din0(din0), .din1(din1), .out_valid(all_v[g]), .dout(all_d[g]),
            .acc_valid(x_acc_valid), .acc_out(x_acc_out), .acc_ovf(x_acc_ovf)
         );
      end
   endgenerate

   // ------------------------------------------------------- reference model
   typedef struct {
      bit            v;
      bit            f;
      bit            l;
      logic [W0-1:0] a;
      logic [W1-1:0] b;
   } beat_t;

   beat_t   hist[$];     // one entry per ce-high clock edge since reset
   beat_t   pk[$];       // packet stimulus for the MAC tests
   longint  got_acc[$];
   bit      got_ovf[$];
   int      got_t[$];
   int      exp_t[$];
   longint  exp_acc[$];
   bit      exp_ovf[$];

   function automatic bit sgn0(int k);
      return (k == 0) || (k == 3);
   endfunction

   function automatic bit sgn1(int k);
      return (k >= 2);
   endfunction

   function automatic longint ext_val(longint x, int w, bit s);
      if (s && (((x >> (w - 1)) & 64'd1) == 64'd1)) return x - (longint'(1) << w);
      return x;
   endfunction

   function automatic longint model_prod(logic [W0-1:0] a, logic [W1-1:0] b, bit s0, bit s1);
      return ext_val(longint'(a), W0, s0) * ext_val(longint'(b), W1, s1);
   endfunction

   function automatic logic [WO-1:0] model_dout(logic [W0-1:0] a, logic [W1-1:0] b, bit s0, bit s1);
      longint p;
      p = model_prod(a, b, s0, s1);
      return p[WO-1:0];
   endfunction

   // The output after a ce edge belongs to the beat accepted NS edges earlier
   function automatic bit exp_valid();
      if (hist.size() >= NS) return hist[hist.size() - NS].v;
      return 1'b0;
   endfunction

   function automatic beat_t exp_beat();
      return hist[hist.size() - NS];
   endfunction

   function automatic beat_t mk(bit v, bit f, bit l, logic [W0-1:0] a, logic [W1-1:0] b);
      beat_t t;
      t.v = v; t.f = f; t.l = l; t.a = a; t.b = b;
      return t;
   endfunction

   // Packet sums straight from the arithmetic rules: load on first, add and
   // clamp otherwise, report on last.
   function automatic void acc_model();
      longint lim_hi, lim_lo, s, t;
      bit     o;
      lim_hi = (longint'(1) << (AW - 1)) - 1;
      lim_lo = -(longint'(1) << (AW - 1));
      s = 0;
      o = 1'b0;
      exp_acc.delete();
      exp_ovf.delete();
      foreach (pk[i]) begin
         if (pk[i].v) begin
            t = model_prod(pk[i].a, pk[i].b, 1'b1, 1'b0);
            if (pk[i].f) begin
               s = t;
               o = 1'b0;
            end else begin
               t = s + t;
               if (t > lim_hi) begin t = lim_hi; o = 1'b1; end
               if (t < lim_lo) begin t = lim_lo; o = 1'b1; end
               s = t;
            end
            if (pk[i].l) begin
               exp_acc.push_back(s);
               exp_ovf.push_back(o);
            end
         end
      end
   endfunction

   // ---------------------------------------------------------------- drivers
   task automatic step(input bit v, input bit f, input bit l,
                       input logic [W0-1:0] a, input logic [W1-1:0] b, input bit c);
      in_valid = v;
      in_first = f;
      in_last  = l;
      din0     = a;
      din1     = b;
      ce       = c;
      @(posedge clk);
      if (c) begin
         hist.push_back(mk(v, f, l, a, b));
         ce_cnt++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic drive_collect();
      idle(NS + 2);
      got_acc.delete(); got_ovf.delete(); got_t.delete(); exp_t.delete();
      foreach (pk[i]) begin
         step(pk[i].v, pk[i].f, pk[i].l, pk[i].a, pk[i].b, 1'b1);
         if (pk[i].v && pk[i].l) exp_t.push_back(ce_cnt);
         if (acc_valid) begin
            got_acc.push_back(ext_val(longint'(acc_out), AW, 1'b1));
            got_ovf.push_back(acc_ovf);
            got_t.push_back(ce_cnt);
         end
      end
      for (int i = 0; i < NS + 4; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
         if (acc_valid) begin
            got_acc.push_back(ext_val(longint'(acc_out), AW, 1'b1));
            got_ovf.push_back(acc_ovf);
            got_t.push_back(ce_cnt);
         end
      end
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL rst_dout: got %h want 0", dout); end
      n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL rst_acc_valid: got %b want 0", acc_valid); end
      n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL rst_acc_out: got %h want 0", acc_out); end
      n_cmp++; if (acc_ovf !== 1'b0) begin n_err++; $display("FAIL rst_acc_ovf: got %b want 0", acc_ovf); end
      reset = 1'b0;
      hist.delete();
      // Fill the pipe with one-beat packets 2x3 so every output is non-zero
      for (int i = 0; i < NS + 3; i++) step(1'b1, 1'b1, 1'b1, 18'd2, 17'd3, 1'b1);
      n_cmp++; if (out_valid !== 1'b1 || dout !== 24'd6) begin n_err++; $display("FAIL fill_dout: got %b/%h want 1/6", out_valid, dout); end
      n_cmp++; if (acc_valid !== 1'b1 || acc_out !== 40'd6) begin n_err++; $display("FAIL fill_acc: got %b/%h want 1/6", acc_valid, acc_out); end
      // Asynchronous assertion in mid-cycle, no clock edge in between
      reset = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || dout !== '0) begin n_err++; $display("FAIL async_rst_dout: got %b/%h want 0/0", out_valid, dout); end
      n_cmp++; if (acc_valid !== 1'b0 || acc_out !== '0 || acc_ovf !== 1'b0) begin
         n_err++; $display("FAIL async_rst_acc: got %b/%h/%b want 0/0/0", acc_valid, acc_out, acc_ovf); end
      #1;
      reset = 1'b0;
      hist.delete();
      step(1'b1, 1'b0, 1'b0, 18'h00123, 17'h00045, 1'b1);
      for (int k = 1; k <= NS; k++) begin
         if (k > 1) idle(1);
         n_cmp++; if (out_valid !== (k == NS)) begin n_err++; $display("FAIL post_rst_latency k=%0d: got %b want %b", k, out_valid, (k == NS)); end
      end
      n_cmp++; if (dout !== model_dout(18'h00123, 17'h00045, 1'b1, 1'b0)) begin
         n_err++; $display("FAIL post_rst_dout: got %h want %h", dout, model_dout(18'h00123, 17'h00045, 1'b1, 1'b0)); end
   endtask

   task automatic test_signed_unsigned();
      idle(NS);
      step(1'b1, 1'b0, 1'b0, 18'h3FFFD, 17'h1FFFF, 1'b1);
      idle(NS - 1);
      n_cmp++; if (out_valid !== 1'b1 || dout !== 24'hFA0003) begin n_err++; $display("FAIL s_x_u: got %b/%h want 1/fa0003", out_valid, dout); end
      step(1'b1, 1'b0, 1'b0, 18'h3FFFF, 17'h1FFFF, 1'b1);
      idle(NS - 1);
      n_cmp++; if (all_v[2] !== 1'b1 || all_d[2] !== 24'hFC0001) begin n_err++; $display("FAIL u_x_s: got %b/%h want 1/fc0001", all_v[2], all_d[2]); end
   endtask

   task automatic test_sign_sweep();
      beat_t e;
      bit    ev;
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), W0'($urandom), W1'($urandom), 1'b1);
         ev = exp_valid();
         for (int k = 0; k < 4; k++) begin
            n_cmp++; if (all_v[k] !== ev) begin n_err++; $display("FAIL sweep_valid dut%0d i=%0d: got %b want %b", k, i, all_v[k], ev); end
            if (ev) begin
               e = exp_beat();
               n_cmp++; if (all_d[k] !== model_dout(e.a, e.b, sgn0(k), sgn1(k))) begin
                  n_err++; $display("FAIL sweep_dout dut%0d i=%0d: got %h want %h", k, i, all_d[k], model_dout(e.a, e.b, sgn0(k), sgn1(k))); end
            end
         end
      end
   endtask

   task automatic test_ce_stall();
      beat_t e;
      bit    ev, c, v;
      int    nvalid, seen, iter;
      idle(NS);
      nvalid = 0; seen = 0; iter = 0;
      while (nvalid < 200 && iter < 3000) begin
         c = 1'($urandom);
         v = ($urandom_range(0, 4) != 0);
         step(v, 1'b0, 1'b0, W0'($urandom), W1'($urandom), c);
         if (v && c) nvalid++;
         iter++;
         ev = exp_valid();
         n_cmp++; if (out_valid !== ev) begin n_err++; $display("FAIL stall_valid it=%0d: got %b want %b", iter, out_valid, ev); end
         if (ev) begin
            e = exp_beat();
            n_cmp++; if (dout !== model_dout(e.a, e.b, 1'b1, 1'b0)) begin
               n_err++; $display("FAIL stall_dout it=%0d: got %h want %h", iter, dout, model_dout(e.a, e.b, 1'b1, 1'b0)); end
         end
         if (c && out_valid) seen++;
      end
      n_cmp++; if (nvalid < 200) begin n_err++; $display("FAIL stall_budget: got %0d beats want 200", nvalid); end
      for (int i = 0; i < NS; i++) begin
         step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
         if (out_valid) seen++;
      end
      n_cmp++; if (seen !== nvalid) begin n_err++; $display("FAIL stall_count: got %0d out_valid beats want %0d", seen, nvalid); end
   endtask

   task automatic test_mac_packets();
      pk.delete();
      pk.push_back(mk(1, 1, 0, 18'd2, 17'd3));
      pk.push_back(mk(1, 0, 0, 18'h3FFFC, 17'd5));
      pk.push_back(mk(1, 0, 1, 18'd7, 17'd1));
      pk.push_back(mk(1, 1, 1, 18'd1, 17'd1));
      drive_collect();
      n_cmp++; if (got_acc.size() != 2) begin n_err++; $display("FAIL mac_pulses: got %0d want 2", got_acc.size()); end
      else begin
         n_cmp++; if (got_acc[0] != -7 || got_ovf[0] !== 1'b0) begin n_err++; $display("FAIL mac_pkt1: got %0d/%b want -7/0", got_acc[0], got_ovf[0]); end
         n_cmp++; if (got_acc[1] != 1 || got_ovf[1] !== 1'b0) begin n_err++; $display("FAIL mac_pkt2: got %0d/%b want 1/0", got_acc[1], got_ovf[1]); end
         n_cmp++; if (got_t[0] != exp_t[0] + NS) begin n_err++; $display("FAIL mac_latency: got %0d want %0d", got_t[0], exp_t[0] + NS); end
      end
      n_cmp++; if (acc_out !== 40'd1 || acc_valid !== 1'b0) begin n_err++; $display("FAIL mac_hold: got %h/%b want 1/0", acc_out, acc_valid); end
   endtask

   task automatic test_saturation();
      pk.delete();
      for (int i = 0; i < 32; i++) pk.push_back(mk(1, i == 0, i == 31, 18'h20000, 17'd131071));
      for (int i = 0; i < 33; i++) pk.push_back(mk(1, i == 0, i == 32, 18'h20000, 17'd131071));
      pk.push_back(mk(1, 1, 1, 18'd2, 17'd3));
      drive_collect();
      n_cmp++; if (got_acc.size() != 3) begin n_err++; $display("FAIL sat_pulses: got %0d want 3", got_acc.size()); end
      else begin
         n_cmp++; if (got_acc[0] != -64'sd549751619584 || got_ovf[0] !== 1'b0) begin
            n_err++; $display("FAIL sat_32: got %0d/%b want -549751619584/0", got_acc[0], got_ovf[0]); end
         n_cmp++; if (got_acc[1] != -64'sd549755813888 || got_ovf[1] !== 1'b1) begin
            n_err++; $display("FAIL sat_33: got %0d/%b want -549755813888/1", got_acc[1], got_ovf[1]); end
         n_cmp++; if (got_acc[2] != 6 || got_ovf[2] !== 1'b0) begin
            n_err++; $display("FAIL sat_clean: got %0d/%b want 6/0", got_acc[2], got_ovf[2]); end
      end
   endtask

   task automatic test_mac_random();
      int len;
      pk.delete();
      for (int p = 0; p < 10; p++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++)
            pk.push_back(mk(1, i == 0, i == len - 1, W0'($urandom), W1'($urandom)));
      end
      acc_model();
      drive_collect();
      n_cmp++; if (got_acc.size() != exp_acc.size()) begin n_err++; $display("FAIL macr_pulses: got %0d want %0d", got_acc.size(), exp_acc.size()); end
      else begin
         foreach (exp_acc[i]) begin
            n_cmp++; if (got_acc[i] != exp_acc[i] || got_ovf[i] !== exp_ovf[i]) begin
               n_err++; $display("FAIL macr_sum p=%0d: got %0d/%b want %0d/%b", i, got_acc[i], got_ovf[i], exp_acc[i], exp_ovf[i]); end
            n_cmp++; if (got_t[i] != exp_t[i] + NS) begin n_err++; $display("FAIL macr_latency p=%0d: got %0d want %0d", i, got_t[i], exp_t[i] + NS); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_signed_unsigned();
      test_sign_sweep();
      test_ce_stall();
      test_mac_packets();
      test_saturation();
      test_mac_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/myproject_mul_pipe_mac.md
# myproject_mul_pipe_mac

Parametrised, pipelined multiplier and multiply-accumulate unit for the LeNet-5 dense and convolution datapaths. It is the successor to the single-cycle combinational `mul_*` cores. Operand widths, operand signedness, pipeline depth and output width are all configurable, and a clock enable stalls the whole pipeline. An optional packet-delimited accumulate mode with saturation lets one instance compute a full dot product per neuron.

## Interface
Parameters:
- `ID`, 1, instance tag; no functional effect
- `NUM_STAGE`, 3, multiplier pipeline depth in cycles, legal range 1..8
- `din0_WIDTH`, 18, width of operand 0
- `din1_WIDTH`, 17, width of operand 1
- `dout_WIDTH`, 24, width of the product output; must be ≤ din0_WIDTH+din1_WIDTH
- `DIN0_SIGNED`, 1, 1 = din0 is two's complement, 0 = unsigned
- `DIN1_SIGNED`, 0, same meaning for din1
- `MAC_EN`, 1, 1 = accumulator present, 0 = accumulator outputs tied to 0
- `ACC_WIDTH`, 40, accumulator width; must be ≥ din0_WIDTH+din1_WIDTH+1

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous reset, active high
- `ce`  in  1  clock enable; when low every register holds its value
- `in_valid`  in  1  operands valid this cycle
- `in_first`  in  1  first beat of an accumulate packet; qualified by in_valid
- `in_last`  in  1  last beat of an accumulate packet; qualified by in_valid
- `din0`  in  din0_WIDTH  operand 0
- `din1`  in  din1_WIDTH  operand 1
- `out_valid`  out  1  dout valid
- `dout`  out  dout_WIDTH  product, truncated
- `acc_valid`  out  1  acc_out valid, single beat
- `acc_out`  out  ACC_WIDTH  saturated packet sum, signed
- `acc_ovf`  out  1  saturation occurred in the packet being reported

## Operation
**Product arithmetic**
- Each operand is extended by one MSB: its sign bit if signed, 0 if unsigned.
- The extended operands are multiplied as signed values. The full product P has width din0_WIDTH+din1_WIDTH and is exact for every signedness combination.
- `dout` = P[dout_WIDTH-1:0]. Truncation wraps; there is no rounding or saturation.

**Pipeline**
- Beats are accepted when in_valid=1 and ce=1.
- in_valid, in_first and in_last travel in a sideband shift register alongside the operands, NUM_STAGE deep.
- out_valid is the sideband valid bit at the final stage.
- There is no backpressure. Downstream stalls via ce only.

**Accumulator (MAC_EN=1)**
- The accumulator is one register stage after the product stage. A product beat leaving the pipeline with valid=1 updates it.
- If that beat has first=1, acc ← sext(P).
- Otherwise, acc ← sat(acc + sext(P)). The sum uses ACC_WIDTH+1 internal bits and clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- ovf_sticky is set when a clamp occurs. A first beat reloads it with that beat's own clamp status, which is always 0.
- A beat with last=1 drives acc_valid=1 for exactly one ce-qualified cycle, presenting the updated acc and ovf_sticky.
- A beat with first=1 and last=1 is a one-element packet; its sum is sext(P).
- A valid beat with first=0 arriving after a last with no new first accumulates onto the held value. This is defined behaviour; upstream must assert first to start a new packet.
- acc_out and acc_ovf hold their values between acc_valid pulses.

**MAC_EN=0**
- acc_valid, acc_out and acc_ovf are held at 0.

## Timing
- **Reset values:** reset=1 asynchronously clears every register. All outputs read 0: out_valid, dout, acc_valid, acc_out, acc_ovf. Reset asserted mid-packet discards the partial sum and all in-flight beats.
- **Product latency:** a beat accepted at ce-cycle n appears on dout with out_valid=1 at ce-cycle n+NUM_STAGE. Only cycles with ce=1 count.
- **Accumulate latency:** acc_valid for a last beat accepted at ce-cycle n rises at ce-cycle n+NUM_STAGE+1.
- **Throughput:** one beat per ce cycle. Back-to-back packets (a last beat followed directly by a first beat) need no bubble.
- **ce low:** while ce=0 all outputs are frozen, including out_valid and acc_valid. A frozen pulse therefore remains visible for the whole stall, and consumers must qualify it with ce.
- in_first and in_last are ignored when in_valid=0.

## Test plan
- **Reset:** assert reset asynchronously mid-stream with the pipeline full. All outputs go to 0 immediately. After release, the first out_valid appears NUM_STAGE cycles after the next accepted beat.
- **Signed × unsigned:** defaults, din0=0x3FFFD (−3), din1=0x1FFFF (131071). After 3 cycles, dout=0xFA0003 (P=−393213) and out_valid=1.
- **Signedness sweep:** with DIN0_SIGNED=0 and DIN1_SIGNED=1, din0=0x3FFFF and din1=0x1FFFF (−1). P=−262143, so dout=0xFC0001. Compare 1000 random beats against a golden model for all four signedness combinations.
- **ce stall:** ce toggling pseudo-randomly over 200 beats. The output sequence matches the ce=1-only model, and out_valid is never duplicated across ce-high cycles.
- **MAC packets:** packet 1 is {2×3, −4×5, 7×1} with first on beat 0 and last on beat 2; packet 2 is a one-beat packet {1×1, first=last=1} sent back-to-back. Expect acc_out=−7 then 1, each with a single acc_valid pulse and acc_ovf=0.
- **Saturation:**
  - 32 beats of din0=0x20000 (−131072), din1=131071 give acc_out=−549751619584 with acc_ovf=0.
  - 33 beats give acc_out=0x8000000000 with acc_ovf=1.
  - The following packet starts clean with acc_ovf=0.
